// File: rtl/case_9_accum_pkg.sv
// Shared widths, FSM state and the saturating narrow helper for the case_9
// product accumulator and its sibling stages.
package case_9_accum_pkg;

  localparam int PROD_WIDTH = 15;
  localparam int ACC_LEN    = 16;
  localparam int ACC_WIDTH  = 19;
  localparam int OUT_WIDTH  = 16;
  localparam int CNT_WIDTH  = 5;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic                 sat;
  } sat_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
  // Bitwise inverse of 0..01..1 is 1..10..0, the most negative output value.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  function automatic sat_t sat_narrow(input logic signed [ACC_WIDTH-1:0] v);
    sat_t r;
    if (v > SAT_MAX) begin
      r.data = SAT_MAX[OUT_WIDTH-1:0];
      r.sat  = 1'b1;
    end else if (v < SAT_MIN) begin
      r.data = SAT_MIN[OUT_WIDTH-1:0];
      r.sat  = 1'b1;
    end else begin
      r.data = v[OUT_WIDTH-1:0];
      r.sat  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/case_9_sat_narrow.sv
// Combinational clip of a wide signed accumulator down to the output width,
// with a flag raised whenever the value had to be clipped.
module case_9_sat_narrow
  import case_9_accum_pkg::*;
(
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  output logic        [OUT_WIDTH-1:0] o_data,
  output logic                        o_sat
);

  sat_t w_res;

  assign w_res  = sat_narrow(i_acc);
  assign o_data = w_res.data;
  assign o_sat  = w_res.sat;

endmodule

// File: rtl/case_9_prod_accum.sv
// Frame accumulator for the signed product stream: sums up to ACC_LEN terms
// (or until in_last) and presents one saturated result per frame.
module case_9_prod_accum
  import case_9_accum_pkg::*;
(
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [PROD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic [CNT_WIDTH-1:0]  out_cnt,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_t r_state;
  state_t w_state_next;

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic        [CNT_WIDTH-1:0] r_cnt;
  logic        [OUT_WIDTH-1:0] r_out_data;
  logic                        r_out_sat;
  logic        [CNT_WIDTH-1:0] r_out_cnt;

  logic                        w_out_valid;
  logic                        w_in_ready;
  logic                        w_accept;
  logic                        w_frame_end;
  logic signed [ACC_WIDTH-1:0] w_in_sext;
  logic signed [ACC_WIDTH-1:0] w_acc_base;
  logic signed [ACC_WIDTH-1:0] w_acc_nxt;
  logic        [OUT_WIDTH-1:0] w_sat_data;
  logic                        w_sat_flag;

  assign w_accept    = in_valid & w_in_ready;
  assign w_frame_end = w_accept & (in_last | (r_cnt == CNT_WIDTH'(ACC_LEN - 1)));
  assign w_in_sext   = {{(ACC_WIDTH - PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
  // A zero count means a fresh frame, so the stale sum is never reused.
  assign w_acc_base  = (r_cnt == '0) ? '0 : r_acc;
  assign w_acc_nxt   = w_acc_base + w_in_sext;

  case_9_sat_narrow u_sat (
    .i_acc  (w_acc_nxt),
    .o_data (w_sat_data),
    .o_sat  (w_sat_flag)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACC:     if (w_frame_end) w_state_next = HOLD;
      HOLD:    if (out_ready) w_state_next = w_frame_end ? HOLD : ACC;
      default: w_state_next = ACC;
    endcase
  end

  always_comb begin
    w_out_valid = (r_state == HOLD);
    w_in_ready  = ~w_out_valid | out_ready;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
      r_out_cnt  <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_frame_end ? '0 : r_cnt + CNT_WIDTH'(1);
      if (w_frame_end) begin
        r_out_data <= w_sat_data;
        r_out_sat  <= w_sat_flag;
        r_out_cnt  <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_case_9_prod_accum.sv
// Directed bench for the case_9 product accumulator with a result scoreboard.
module tb_case_9_prod_accum;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [14:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic [4:0]  out_cnt;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    int data;
    int sat;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_acc  = 0;
  int   m_cnt  = 0;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_out_data;
  logic [4:0]  s_out_cnt;

  always #5 ap_clk = ~ap_clk;

  case_9_prod_accum dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_cnt   (out_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input int d, input bit last);
    exp_t e;
    m_acc += d;
    m_cnt++;
    if (last || m_cnt == 16) begin
      if (m_acc > 32767) begin
        e.data = 32767;  e.sat = 1;
      end else if (m_acc < -32768) begin
        e.data = -32768; e.sat = 1;
      end else begin
        e.data = m_acc;  e.sat = 0;
      end
      e.cnt = m_cnt;
      q.push_back(e);
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  // One clock: snapshot and scoreboard at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge ap_clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_out_cnt   = out_cnt;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_empty: observed unexpected result %0d expected none", $signed(out_data));
      end else begin
        e = q.pop_front();
        chk("sb_data", $signed(out_data), e.data);
        chk("sb_sat",  int'(out_sat), e.sat);
        chk("sb_cnt",  int'(out_cnt), e.cnt);
        $display("result data=%0d sat=%0d cnt=%0d", $signed(out_data), out_sat, out_cnt);
      end
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send_beat(input int d, input bit last, output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    in_valid = 1'b1;
    in_data  = 15'(d);
    in_last  = last;
    for (int i = 0; i < 50; i++) begin
      tick();
      cycles++;
      if (s_in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed no accept expected accept of %0d", d);
    end else begin
      model_beat(d, last);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cyc;
    int total;
    ap_rst    = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data",  $signed(out_data), 0);
    chk("rst_sat",   int'(out_sat), 0);
    chk("rst_cnt",   int'(out_cnt), 0);
    chk("rst_ready", int'(in_ready), 1);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;

    // Positive saturation over a full-length frame, plus result latency.
    for (int i = 0; i < 16; i++) begin
      send_beat(8192, 1'b0, cyc);
      if (i == 14) chk("t1_no_early_valid", int'(out_valid), 0);
    end
    chk("t1_valid_next_cycle", int'(out_valid), 1);
    idle(2);

    // Negative saturation, then an in-range short frame.
    for (int i = 0; i < 16; i++) send_beat(-8128, 1'b0, cyc);
    idle(2);
    for (int i = 0; i < 4; i++) send_beat(-8128, i == 3, cyc);
    idle(2);

    // Mixed signs with early last, then a fresh frame starting from zero.
    send_beat(100, 1'b0, cyc);
    send_beat(-50, 1'b0, cyc);
    send_beat(7, 1'b1, cyc);
    send_beat(5, 1'b1, cyc);
    idle(2);

    // Back-pressure: result holds, input stalls, then retire and accept together.
    out_ready = 1'b0;
    send_beat(10, 1'b0, cyc);
    send_beat(20, 1'b0, cyc);
    send_beat(30, 1'b1, cyc);
    in_valid = 1'b1;
    in_data  = 15'(5);
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_ready", int'(s_in_ready), 0);
      chk("t4_hold_valid", int'(s_out_valid), 1);
      chk("t4_hold_data",  $signed(s_out_data), 60);
      chk("t4_hold_cnt",   int'(s_out_cnt), 3);
    end
    out_ready = 1'b1;
    model_beat(5, 1'b1);
    tick();
    chk("t4_release_ready", int'(s_in_ready), 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("t4_reload_valid", int'(out_valid), 1);
    chk("t4_reload_data",  $signed(out_data), 5);
    idle(2);

    // Single-beat frames every cycle with no bubbles.
    total = 0;
    for (int i = 1; i <= 8; i++) begin
      send_beat(i, 1'b1, cyc);
      total += cyc;
    end
    chk("t5_cycles", total, 8);
    chk("t5_valid_after", int'(out_valid), 1);
    idle(2);

    // in_last on the ACC_LEN-th beat ends exactly one frame.
    for (int i = 0; i < 16; i++) send_beat(1, i == 15, cyc);
    idle(3);

    // Reset mid-frame discards the partial sum.
    for (int i = 0; i < 7; i++) send_beat(1000, 1'b0, cyc);
    ap_rst = 1'b1;
    #3;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_data",  $signed(out_data), 0);
    chk("t6_rst_sat",   int'(out_sat), 0);
    chk("t6_rst_cnt",   int'(out_cnt), 0);
    ap_rst = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    @(posedge ap_clk);
    #1;
    send_beat(3, 1'b0, cyc);
    send_beat(4, 1'b1, cyc);
    idle(3);

    chk("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
